// File: rtl/vx_dispatch_rcv.sv
// Dispatch receiver: buffers NUM_THREADS-wide dispatch packets and splits each into NUM_LANES-wide execute beats.
// Optional macro VX_DISPATCH_RCV_SKIP_EN skips beats whose lane-mask slice is all zero.
module vx_dispatch_rcv #(
  parameter int LANEW       = 32,
  parameter int SIDEW       = 64,
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int DEPTH       = 2,
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  localparam int PIDW        = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1,
  localparam int CNTW        = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [NUM_THREADS-1:0]       in_tmask,
  input  logic [NUM_THREADS*LANEW-1:0] in_data,
  input  logic [SIDEW-1:0]             in_side,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [NUM_LANES-1:0]         out_tmask,
  output logic [NUM_LANES*LANEW-1:0]   out_data,
  output logic [SIDEW-1:0]             out_side,
  output logic [PIDW-1:0]              out_pid,
  output logic                         out_sop,
  output logic                         out_eop,
  input  logic                         out_ready,
  output logic [CNTW-1:0]              count,
  output logic                         o_dbg_state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int BEAT = NUM_LANES * LANEW;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // once out_valid is up, every out_* holds until out_ready accepts the beat.

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  logic [NUM_THREADS*LANEW-1:0] r_data  [DEPTH];
  logic [NUM_THREADS-1:0]       r_tmask [DEPTH];
  logic [SIDEW-1:0]             r_side  [DEPTH];
  logic [AW-1:0]                r_wptr, r_rptr;
  logic [CNTW-1:0]              r_count;
  logic [PIDW-1:0]              r_pid;
  logic                         r_sop;
  state_t                       r_state, w_state_nxt;

  logic                         w_push, w_fire, w_pop, w_eop;
  logic [NUM_THREADS*LANEW-1:0] w_head_data;
  logic [NUM_THREADS-1:0]       w_head_tmask;
  logic [PIDW-1:0]              w_cur, w_next, w_last;

  assign w_head_data  = r_data[r_rptr];
  assign w_head_tmask = r_tmask[r_rptr];

  assign in_ready = !reset && (r_count != CNTW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_fire   = out_valid && out_ready;
  assign w_pop    = w_fire && w_eop;

`ifdef VX_DISPATCH_RCV_SKIP_EN
  logic [NUM_PACKETS-1:0] w_nz;
  logic [PIDW-1:0]        w_first;

  // Beat selection walks only the non-empty slices; an all-empty packet still issues pid 0.
  always_comb begin
    w_nz    = '0;
    w_first = '0;
    w_last  = '0;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      w_nz[p] = |w_head_tmask[p*NUM_LANES +: NUM_LANES];
    end
    for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
      if (w_nz[p]) w_first = PIDW'(p);
    end
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (w_nz[p]) w_last = PIDW'(p);
    end
    w_cur  = r_sop ? w_first : r_pid;
    w_next = w_cur;
    for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
      if (w_nz[p] && (PIDW'(p) > w_cur)) w_next = PIDW'(p);
    end
  end
`else
  always_comb begin
    w_last = PIDW'(NUM_PACKETS - 1);
    w_cur  = r_pid;
    w_next = r_pid + PIDW'(1);
  end
`endif

  assign w_eop     = (w_cur == w_last);
  assign out_valid = (r_state == S_ISSUE);
  assign out_tmask = w_head_tmask[w_cur*NUM_LANES +: NUM_LANES];
  assign out_data  = w_head_data[w_cur*BEAT +: BEAT];
  assign out_side  = r_side[r_rptr];
  assign out_pid   = w_cur;
  assign out_sop   = r_sop;
  assign out_eop   = w_eop;
  assign count     = r_count;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr]  <= in_data;
        r_tmask[r_wptr] <= in_tmask;
        r_side[r_wptr]  <= in_side;
        r_wptr          <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pid <= '0;
      r_sop <= 1'b1;
    end else if (w_fire) begin
      r_pid <= w_eop ? '0 : w_next;
      r_sop <= w_eop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ISSUE tracks "FIFO non-empty after this edge", which gives one-cycle latency.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_push) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_pop && !w_push && (r_count == CNTW'(1))) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
